// File: rtl/tournament_branch_predictor_if.sv
// Branch event bus for the tournament predictor: resolved outcome and branch id in,
// predictor counters, misprediction count and global history out.
interface tournament_branch_predictor_if #(
    parameter int BR_W  = 1,
    parameter int GH_W  = 5,
    parameter int CNT_W = 32
);
    logic              in;
    logic [BR_W-1:0]   branchnumber;
    logic [1:0]        predict52;
    logic [1:0]        predict2l;
    logic [1:0]        predict;
    logic [CNT_W-1:0]  mismatch;
    logic [GH_W-1:0]   globalhistory;

    modport master (
        output in, branchnumber,
        input  predict52, predict2l, predict, mismatch, globalhistory
    );

    modport slave (
        input  in, branchnumber,
        output predict52, predict2l, predict, mismatch, globalhistory
    );
endinterface

// File: rtl/tournament_branch_predictor.sv
// Tournament branch predictor: global (5,2) correlating table vs per-branch two-level local
// table, picked by a per-branch 2-bit chooser; one resolved branch per clock.
module tournament_branch_predictor #(
    parameter int BR_W  = 1,
    parameter int GH_W  = 5,
    parameter int LH_W  = 2,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic reset,
    tournament_branch_predictor_if.slave bp
);
    localparam int GI_W = BR_W + GH_W;
    localparam int LI_W = BR_W + LH_W;
    localparam int NG   = 1 << GI_W;
    localparam int NL   = 1 << LI_W;
    localparam int NB   = 1 << BR_W;

    logic [1:0]       gpht_reg [NG];
    logic [1:0]       lpht_reg [NL];
    logic [1:0]       cho_reg  [NB];
    logic [LH_W-1:0]  lht_reg  [NB];
    logic [GH_W-1:0]  ghist_reg;
    logic [CNT_W-1:0] mismatch_reg;

    logic [GI_W-1:0] g_idx;
    logic [LI_W-1:0] l_idx;
    logic [1:0]      p52, p2l, pred;
    logic [1:0]      gpht_next, lpht_next, cho_next;
    logic            cho_upd, miss;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    always_comb begin
        g_idx     = {bp.branchnumber, ghist_reg};
        l_idx     = {bp.branchnumber, lht_reg[bp.branchnumber]};
        p52       = gpht_reg[g_idx];
        p2l       = lpht_reg[l_idx];
        // Chooser MSB set means the global predictor is currently trusted
        pred      = cho_reg[bp.branchnumber][1] ? p52 : p2l;
        miss      = pred[1] ^ bp.in;
        cho_upd   = p52[1] ^ p2l[1];
        cho_next  = sat_step(cho_reg[bp.branchnumber], p52[1] == bp.in);
        gpht_next = sat_step(p52, bp.in);
        lpht_next = sat_step(p2l, bp.in);
    end

    assign bp.predict52     = p52;
    assign bp.predict2l     = p2l;
    assign bp.predict       = pred;
    assign bp.mismatch      = mismatch_reg;
    assign bp.globalhistory = ghist_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_gpht
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    gpht_reg[gi] <= 2'b01;
                else if (g_idx == GI_W'(gi))
                    gpht_reg[gi] <= gpht_next;
            end
        end

        for (gi = 0; gi < NL; gi++) begin : g_lpht
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    lpht_reg[gi] <= 2'b01;
                else if (l_idx == LI_W'(gi))
                    lpht_reg[gi] <= lpht_next;
            end
        end

        // Only the current branch's history and chooser move on each event
        for (gi = 0; gi < NB; gi++) begin : g_branch
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lht_reg[gi] <= '0;
                    cho_reg[gi] <= 2'b10;
                end else if (bp.branchnumber == BR_W'(gi)) begin
                    lht_reg[gi] <= {lht_reg[gi][LH_W-2:0], bp.in};
                    if (cho_upd)
                        cho_reg[gi] <= cho_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghist_reg    <= '0;
            mismatch_reg <= '0;
        end else begin
            ghist_reg <= {ghist_reg[GH_W-2:0], bp.in};
            if (miss && (mismatch_reg != {CNT_W{1'b1}}))
                mismatch_reg <= mismatch_reg + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Bench for tournament_branch_predictor: directed event streams checked every cycle
// against a table-level model, plus hand-computed literal expectations.
module tb_tournament_branch_predictor;
    localparam int GH_N = 32;
    localparam int LH_N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_v = 1'b0;
    logic br_v = 1'b0;
    bit   armed = 1'b0;

    int cmp_count = 0;
    int fail_count = 0;

    // Model state: plain integer tables indexed arithmetically
    int gp [64];
    int lp [8];
    int ch [2];
    int lh [2];
    int gh;
    logic [31:0] mis32;
    int mis3;

    tournament_branch_predictor_if #(.BR_W(1), .GH_W(5), .CNT_W(32)) bp32 ();
    tournament_branch_predictor_if #(.BR_W(1), .GH_W(5), .CNT_W(3))  bp3 ();

    assign bp32.in = in_v;
    assign bp32.branchnumber = br_v;
    assign bp3.in = in_v;
    assign bp3.branchnumber = br_v;

    tournament_branch_predictor #(.BR_W(1), .GH_W(5), .LH_W(2), .CNT_W(32)) dut32 (
        .clk(clk), .reset(rst_n), .bp(bp32)
    );
    tournament_branch_predictor #(.BR_W(1), .GH_W(5), .LH_W(2), .CNT_W(3)) dut3 (
        .clk(clk), .reset(rst_n), .bp(bp3)
    );

    always #5 clk = ~clk;

    function automatic int sat(int c, int up);
        if (up != 0) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int m_p52(int b);
        return gp[b * GH_N + gh];
    endfunction

    function automatic int m_p2l(int b);
        return lp[b * LH_N + lh[b]];
    endfunction

    function automatic int m_pred(int b);
        return (ch[b] >= 2) ? m_p52(b) : m_p2l(b);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) gp[i] = 1;
        for (int i = 0; i < 8; i++) lp[i] = 1;
        for (int i = 0; i < 2; i++) begin
            ch[i] = 2;
            lh[i] = 0;
        end
        gh = 0;
        mis32 = 32'd0;
        mis3 = 0;
    endtask

    task automatic model_update(int b, int t);
        int p52, p2l, p, gidx, lidx;
        gidx = b * GH_N + gh;
        lidx = b * LH_N + lh[b];
        p52 = gp[gidx];
        p2l = lp[lidx];
        p = (ch[b] >= 2) ? p52 : p2l;
        if ((p >= 2) != (t == 1)) begin
            if (mis32 != 32'hFFFF_FFFF) mis32 = mis32 + 32'd1;
            if (mis3 < 7) mis3++;
        end
        if ((p52 >= 2) != (p2l >= 2))
            ch[b] = sat(ch[b], ((p52 >= 2) == (t == 1)) ? 1 : 0);
        gp[gidx] = sat(p52, t);
        lp[lidx] = sat(p2l, t);
        gh = (gh * 2 + t) % GH_N;
        lh[b] = (lh[b] * 2 + t) % LH_N;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (armed && rst_n) model_update(int'(br_v), int'(in_v));
    end

    always @(negedge clk) begin
        if (armed && rst_n) begin
            check("p52_32",  32'(bp32.predict52),     32'(m_p52(int'(br_v))));
            check("p2l_32",  32'(bp32.predict2l),     32'(m_p2l(int'(br_v))));
            check("pred_32", 32'(bp32.predict),       32'(m_pred(int'(br_v))));
            check("mis_32",  bp32.mismatch,           mis32);
            check("gh_32",   32'(bp32.globalhistory), 32'(gh));
            check("pred_3",  32'(bp3.predict),        32'(m_pred(int'(br_v))));
            check("mis_3",   32'(bp3.mismatch),       32'(mis3));
        end
    end

    task automatic set_in(int b, int t);
        br_v = b[0];
        in_v = t[0];
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        $display("ev br=%0d in=%0d pred=%0d mis=%0d gh=%b", br_v, in_v,
                 bp32.predict, bp32.mismatch, bp32.globalhistory);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_p52"},  32'(bp32.predict52),     32'd1);
        check({tag, "_p2l"},  32'(bp32.predict2l),     32'd1);
        check({tag, "_pred"}, 32'(bp32.predict),       32'd1);
        check({tag, "_mis"},  bp32.mismatch,           32'd0);
        check({tag, "_gh"},   32'(bp32.globalhistory), 32'd0);
        check({tag, "_mis3"}, 32'(bp3.mismatch),       32'd0);
    endtask

    // Reset falls mid-cycle; outputs must clear before any further edge
    task automatic do_reset(string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        armed = 1'b1;
    endtask

    initial begin
        do_reset("rst1");

        // Always-taken on branch 0: four warm-up misses then steady
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1);
            step();
        end
        check("s2_mis",  bp32.mismatch,           32'd4);
        check("s2_gh",   32'(bp32.globalhistory), 32'h1F);
        check("s2_pred", 32'(bp32.predict),       32'd3);
        check("s2_p2l",  32'(bp32.predict2l),     32'd3);

        for (int i = 0; i < 20; i++) begin
            set_in(0, (i % 2 == 0) ? 1 : 0);
            step();
        end

        do_reset("rst2");
        for (int i = 0; i < 16; i++) begin
            set_in(i % 2, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 1)
                check("s4_br1_p2l", 32'(bp32.predict2l), (i == 1) ? 32'd1 : 32'd0);
            step();
        end

        // Drive the opposite of the expected prediction so every event misses
        do_reset("rst3");
        for (int i = 0; i < 12; i++) begin
            set_in(0, (m_pred(0) >= 2) ? 0 : 1);
            step();
            if (i == 6) check("s5_mis3_at7", 32'(bp3.mismatch), 32'd7);
        end
        check("s5_mis3_hold", 32'(bp3.mismatch), 32'd7);
        check("s5_mis32",     bp32.mismatch,     32'd12);

        do_reset("rst4");
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1);
            step();
        end
        check("s6_mis_pre", bp32.mismatch, 32'd4);
        do_reset("rst5");
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1);
            step();
        end
        check("s6_mis_rerun", bp32.mismatch,           32'd4);
        check("s6_gh_rerun",  32'(bp32.globalhistory), 32'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
